multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Sequencing FSM for the multicycle RV32I core variant: one shared ALU and one unified instruction/data memory.
//  Steps each instruction through fetch/decode/execute/memory/writeback states.
//  Drives all datapath mux selects and write enables.
//  Supports lw, sw, R-type, I-type ALU, beq, jal, jalr.
//  Stalls on a memory-ready handshake; flags unsupported opcodes.
// PARAMETERS
//  none (encodings fixed by ctrl_pkg)
// PORTS
//  clk        in   1  core clock; all state changes on rising edge
//  rst        in   1  asynchronous, active-high reset
//  op         in   7  opcode from instruction register (stable after FETCH)
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  memory completes the current access this cycle
//  mem_req    out  1  memory access requested (FETCH/MEMREAD/MEMWRITE)
//  adrsrc     out  1  mem address: 0=PC, 1=ALUOut
//  irwrite    out  1  load instruction reg and oldPC
//  pcwrite    out  1  PC load enable
//  memwrite   out  1  data write strobe
//  regwrite   out  1  register file write enable
//  resultsrc  out  2  00=ALUOut 01=MemData 10=ALUResult
//  alusrca    out  2  00=PC 01=oldPC 10=A(rs1)
//  alusrcb    out  2  00=B(rs2) 01=ImmExt 10=const 4
//  immsrc     out  2  00=I 01=S 10=B 11=J; decoded from op in every state
//  aluop      out  2  00=add 01=sub(compare) 10=funct-decoded; to alu_decoder
//  illegal_op out  1  one-cycle pulse: unsupported opcode seen in DECODE
// BEHAVIOUR
//  Moore FSM with async reset to FETCH. While rst=1, all enables are 0:
//   mem_req, irwrite, pcwrite, memwrite, regwrite, illegal_op.
//  While rst=1, selects and aluop are 0 and immsrc follows op.
//  Unlisted outputs in any state are 0.
//  FETCH: mem_req, adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10.
//   irwrite=pcwrite=mem_ready. Stay while !mem_ready; else DECODE.
//  DECODE: alusrca=01, alusrcb=01, aluop=00 (branch/jal target -> ALUOut).
//   op routing: lw/sw->MEMADR; R->EXECR; I->EXECI; beq->BEQ; jal->JAL; jalr->JALR_LINK.
//   Any other op: illegal_op=1 for this cycle, then FETCH (instruction skipped).
//  MEMADR: alusrca=10, alusrcb=01, aluop=00. lw->MEMREAD; sw->MEMWRITE.
//  MEMREAD: mem_req, adrsrc=1, resultsrc=00. Hold until mem_ready, then MEMWB.
//  MEMWB: resultsrc=01, regwrite=1 -> FETCH.
//  MEMWRITE: mem_req, adrsrc=1, memwrite=1 (held while waiting).
//   Leave to FETCH on the cycle mem_ready=1.
//  EXECR: alusrca=10, alusrcb=00, aluop=10 -> ALUWB.
//  EXECI: alusrca=10, alusrcb=01, aluop=10 -> ALUWB.
//  ALUWB: resultsrc=00, regwrite=1 -> FETCH.
//  BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, pcwrite=zero -> FETCH.
//  JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcwrite=1 -> ALUWB.
//   PC <- target; rd <- oldPC+4.
//  JALR_LINK: alusrca=01, alusrcb=10, resultsrc=10, regwrite=1 -> JALR_JUMP.
//   rd <- oldPC+4; rs1 already latched in A, so rd==rs1 is safe.
//  JALR_JUMP: alusrca=10, alusrcb=01, resultsrc=10, pcwrite=1 -> FETCH.
//   PC <- rs1+imm; bit0 clearing is done in the datapath.
//  Cycles with mem_ready tied 1:
//   lw 5; sw/R/I/jal/jalr 4; beq 3; illegal 2.
//  Each stall cycle adds 1.
//  Reset mid-instruction: immediate return to FETCH, no partial write.
//  Unreachable state encodings -> FETCH.
// STRUCTURE
//  ctrl_pkg holds:
//   state_t enum (13 states), opcode localparams, resultsrc/alusrc/immsrc/aluop constants.
//  Sub-module mc_state_outputs: pure combinational state -> control-word table.
//  Top keeps the state register, next-state logic, and mem_ready/zero qualification.
// TESTING
//  1. lw (op=0000011), mem_ready=1: states F,D,MA,MR,WB.
//     regwrite=1 only in cycle 5, resultsrc=01.
//  2. lw with mem_ready low 2 cycles in FETCH and 3 in MEMREAD: 10 cycles total.
//     irwrite/pcwrite only on the ready FETCH cycle.
//  3. beq: zero=1 -> pcwrite=1 in cycle 3; zero=0 -> pcwrite=0; aluop=01 both cases.
//  4. jalr: regwrite in cycle 3 with alusrca=01/alusrcb=10.
//     pcwrite in cycle 4 with alusrca=10/alusrcb=01; next state FETCH.
//  5. op=0110111 (unsupported): illegal_op=1 exactly in cycle 2.
//     No regwrite/memwrite; FETCH in cycle 3.
//  6. sw with rst asserted in MEMWRITE while mem_ready=0: memwrite drops same cycle (async).
//     After release: FETCH with mem_req=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
//   Shared encodings for the multicycle RV32I controller: FSM state type,
//   opcode constants, datapath mux-select constants, the per-state control
//   word, and small opcode helper functions.
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXECR     = 4'd6,
        S_EXECI     = 4'd7,
        S_ALUWB     = 4'd8,
        S_BEQ       = 4'd9,
        S_JAL       = 4'd10,
        S_JALR_LINK = 4'd11,
        S_JALR_JUMP = 4'd12
    } state_t;

    // Opcodes of the supported instruction classes
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Result mux
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand A mux
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B mux
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate format
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALU operation class handed to the ALU decoder
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Raw per-state control word; handshake/flag qualification is applied
    // in the top level.
    typedef struct packed {
        logic       mem_req;
        logic       adrsrc;
        logic       irwrite;
        logic       pcwrite;
        logic       memwrite;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Immediate format implied by an opcode; formats without an immediate
    // (R-type, unsupported) fall back to I.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_JALR: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_state_outputs.sv
// ---------------------------------------------------------------------------
// mc_state_outputs
//   Pure combinational state -> control-word table for the multicycle
//   controller.
//   Ports:
//     state      in   current FSM state
//     ctrl       out  unqualified control word for that state
//     gate_ready out  irwrite/pcwrite of this state wait for mem_ready
//     gate_zero  out  pcwrite of this state is conditional on the zero flag
// ---------------------------------------------------------------------------
module mc_state_outputs
    import ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl,
    output logic   gate_ready,
    output logic   gate_zero
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // through the block leaves a value unassigned (no latch inferred).
        ctrl       = CTRL_IDLE;
        gate_ready = 1'b0;
        gate_zero  = 1'b0;

        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.irwrite   = 1'b1;
                ctrl.pcwrite   = 1'b1;
                ctrl.alusrca   = SRCA_PC;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.aluop     = ALU_ADD;
                ctrl.resultsrc = RES_ALURESULT;
                gate_ready     = 1'b1;
            end
            S_DECODE: begin
                // Branch/jal target oldPC+imm is precomputed into ALUOut
                ctrl.alusrca = SRCA_OLDPC;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alusrca = SRCA_RS1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALU_ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_req   = 1'b1;
                ctrl.adrsrc    = 1'b1;
                ctrl.resultsrc = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.resultsrc = RES_MEMDATA;
                ctrl.regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe stays up for the whole wait, memory samples it on ready
                ctrl.mem_req  = 1'b1;
                ctrl.adrsrc   = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_EXECR: begin
                ctrl.alusrca = SRCA_RS1;
                ctrl.alusrcb = SRCB_RS2;
                ctrl.aluop   = ALU_FUNCT;
            end
            S_EXECI: begin
                ctrl.alusrca = SRCA_RS1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.regwrite  = 1'b1;
            end
            S_BEQ: begin
                ctrl.alusrca   = SRCA_RS1;
                ctrl.alusrcb   = SRCB_RS2;
                ctrl.aluop     = ALU_SUB;
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.pcwrite   = 1'b1;
                gate_zero      = 1'b1;
            end
            S_JAL: begin
                // PC <- target held in ALUOut; ALU forms oldPC+4 for the link
                ctrl.alusrca   = SRCA_OLDPC;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.aluop     = ALU_ADD;
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.pcwrite   = 1'b1;
            end
            S_JALR_LINK: begin
                // Link is written first; rs1 is already captured in A
                ctrl.alusrca   = SRCA_OLDPC;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.resultsrc = RES_ALURESULT;
                ctrl.regwrite  = 1'b1;
            end
            S_JALR_JUMP: begin
                ctrl.alusrca   = SRCA_RS1;
                ctrl.alusrcb   = SRCB_IMM;
                ctrl.resultsrc = RES_ALURESULT;
                ctrl.pcwrite   = 1'b1;
            end
            default: begin
                ctrl       = CTRL_IDLE;
                gate_ready = 1'b0;
                gate_zero  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//   Sequencing FSM for the multicycle RV32I core (shared ALU, unified
//   memory). Steps instructions through fetch/decode/execute/memory/
//   writeback and drives every datapath select and write enable.
//   Ports:
//     clk, rst               clock; asynchronous active-high reset
//     op                     opcode from the instruction register
//     zero                   ALU zero flag (beq)
//     mem_ready              memory completes the current access this cycle
//     mem_req, adrsrc        memory request and address select
//     irwrite, pcwrite       IR/oldPC and PC load enables
//     memwrite, regwrite     data memory / register file write enables
//     resultsrc, alusrca,
//     alusrcb, immsrc, aluop datapath selects
//     illegal_op             pulse when DECODE sees an unsupported opcode
// ---------------------------------------------------------------------------
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] immsrc,
    output logic [1:0] aluop,
    output logic       illegal_op
);

    state_t state_q, state_d;
    ctrl_t  ctrl_raw;
    logic   gate_ready;
    logic   gate_zero;
    logic   qual;
    logic   live;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR_LINK;
                    default:      state_d = S_FETCH;   // unsupported: skip
                endcase
            end
            S_MEMADR: begin
                case (op)
                    OP_LW:   state_d = S_MEMREAD;
                    OP_SW:   state_d = S_MEMWRITE;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMREAD:   state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:     state_d = S_FETCH;
            S_MEMWRITE:  state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:     state_d = S_ALUWB;
            S_EXECI:     state_d = S_ALUWB;
            S_ALUWB:     state_d = S_FETCH;
            S_BEQ:       state_d = S_FETCH;
            S_JAL:       state_d = S_ALUWB;
            S_JALR_LINK: state_d = S_JALR_JUMP;
            S_JALR_JUMP: state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    mc_state_outputs u_outputs (
        .state      (state_q),
        .ctrl       (ctrl_raw),
        .gate_ready (gate_ready),
        .gate_zero  (gate_zero)
    );

    // Reset blanks the control word directly so a write in flight drops in
    // the same cycle reset rises, without waiting for a clock edge.
    assign live = ~rst;
    assign qual = (~gate_ready | mem_ready) & (~gate_zero | zero);

    assign mem_req    = live & ctrl_raw.mem_req;
    assign adrsrc     = live & ctrl_raw.adrsrc;
    assign irwrite    = live & ctrl_raw.irwrite & qual;
    assign pcwrite    = live & ctrl_raw.pcwrite & qual;
    assign memwrite   = live & ctrl_raw.memwrite;
    assign regwrite   = live & ctrl_raw.regwrite;
    assign resultsrc  = live ? ctrl_raw.resultsrc : 2'b00;
    assign alusrca    = live ? ctrl_raw.alusrca   : 2'b00;
    assign alusrcb    = live ? ctrl_raw.alusrcb   : 2'b00;
    assign aluop      = live ? ctrl_raw.aluop     : 2'b00;
    assign immsrc     = imm_src_of(op);
    assign illegal_op = live & (state_q == S_DECODE) & ~op_supported(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//   Self-checking bench: each issued instruction is expanded by a reference
//   model into its expected per-cycle control outputs, which are queued; a
//   monitor pops one entry per cycle and compares. Directed reset checks
//   cover the asynchronous reset behaviour.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, adrsrc, irwrite, pcwrite, memwrite, regwrite, illegal_op;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc, aluop;

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .adrsrc     (adrsrc),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .resultsrc  (resultsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .immsrc     (immsrc),
        .aluop      (aluop),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BEQ = 7'b1100011, JAL = 7'b1101111,
                           JALR = 7'b1100111, LUI = 7'b0110111;

    typedef struct packed {
        logic       mem_req;
        logic       adrsrc;
        logic       irwrite;
        logic       pcwrite;
        logic       memwrite;
        logic       regwrite;
        logic       illegal_op;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] immsrc;
        logic [1:0] aluop;
    } obs_t;

    typedef struct {
        obs_t exp;
        int   instr;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];
    bit   pl_mr[$];
    bit   pl_z[$];
    obs_t pl_e[$];
    int   checks = 0;
    int   errors = 0;
    int   n_instr = 0;
    obs_t actual;

    always_comb actual = {mem_req, adrsrc, irwrite, pcwrite, memwrite, regwrite,
                          illegal_op, resultsrc, alusrca, alusrcb, immsrc, aluop};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected control word per clock, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("ctrl i%0d c%0d", e.instr, e.cyc), 32'(actual), 32'(e.exp));
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [1:0] model_imm(input logic [6:0] o);
        if (o == SW)  return 2'b01;
        if (o == BEQ) return 2'b10;
        if (o == JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit model_legal(input logic [6:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == IT) ||
               (o == BEQ) || (o == JAL) || (o == JALR);
    endfunction

    function automatic obs_t mk(input bit mq, input bit ad, input bit irw, input bit pcw,
                                input bit mw, input bit rw, input bit ill,
                                input logic [1:0] rs, input logic [1:0] a,
                                input logic [1:0] b, input logic [1:0] alu,
                                input logic [6:0] o);
        obs_t r;
        r = {mq, ad, irw, pcw, mw, rw, ill, rs, a, b, model_imm(o), alu};
        return r;
    endfunction

    task automatic plan(input bit mr, input bit z, input obs_t e);
        pl_mr.push_back(mr);
        pl_z.push_back(z);
        pl_e.push_back(e);
    endtask

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into cycles, queue expectations, then drive.
    // sf/sm: stall cycles in fetch / memory access; zmode<0 -> random zero.
    // abort_mw stops inside the first store wait cycle (for the reset test).
    task automatic issue(input logic [6:0] o, input int sf, input int sm,
                         input int zmode, input bit abort_mw);
        bit zz;
        pl_mr.delete(); pl_z.delete(); pl_e.delete();
        for (int i = 0; i < sf; i++)
            plan(1'b0, rnd(), mk(1,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, o));
        plan(1'b1, rnd(), mk(1,0,1,1,0,0,0, 2'b10,2'b00,2'b10,2'b00, o));
        plan(rnd(), rnd(), mk(0,0,0,0,0,0,!model_legal(o), 2'b00,2'b01,2'b01,2'b00, o));
        if (o == LW || o == SW)
            plan(rnd(), rnd(), mk(0,0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, o));
        if (o == LW) begin
            for (int i = 0; i < sm; i++)
                plan(1'b0, rnd(), mk(1,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, o));
            plan(1'b1, rnd(), mk(1,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, o));
            plan(rnd(), rnd(), mk(0,0,0,0,0,1,0, 2'b01,2'b00,2'b00,2'b00, o));
        end else if (o == SW) begin
            if (abort_mw) begin
                plan(1'b0, rnd(), mk(1,1,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00, o));
            end else begin
                for (int i = 0; i < sm; i++)
                    plan(1'b0, rnd(), mk(1,1,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00, o));
                plan(1'b1, rnd(), mk(1,1,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00, o));
            end
        end else if (o == RT || o == IT) begin
            plan(rnd(), rnd(), mk(0,0,0,0,0,0,0, 2'b00,2'b10,(o == RT) ? 2'b00 : 2'b01,2'b10, o));
            plan(rnd(), rnd(), mk(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, o));
        end else if (o == BEQ) begin
            zz = (zmode < 0) ? rnd() : (zmode != 0);
            plan(rnd(), zz, mk(0,0,0,zz,0,0,0, 2'b00,2'b10,2'b00,2'b01, o));
        end else if (o == JAL) begin
            plan(rnd(), rnd(), mk(0,0,0,1,0,0,0, 2'b00,2'b01,2'b10,2'b00, o));
            plan(rnd(), rnd(), mk(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, o));
        end else if (o == JALR) begin
            plan(rnd(), rnd(), mk(0,0,0,0,0,1,0, 2'b10,2'b01,2'b10,2'b00, o));
            plan(rnd(), rnd(), mk(0,0,0,1,0,0,0, 2'b10,2'b10,2'b01,2'b00, o));
        end

        for (int i = 0; i < pl_e.size(); i++)
            exp_q.push_back('{exp: pl_e[i], instr: n_instr, cyc: i + 1});
        n_instr++;

        // Caller enters just after a rising edge, at the start of FETCH
        op = o;
        for (int i = 0; i < pl_e.size(); i++) begin
            mem_ready = pl_mr[i];
            zero      = pl_z[i];
            if (!(abort_mw && i == pl_e.size() - 1)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    logic [6:0] op_tab [8];
    obs_t       rst_vec;
    logic [6:0] ro;

    initial begin
        op_tab = '{LW, SW, RT, IT, BEQ, JAL, JALR, LUI};
        rst = 1'b1; op = SW; zero = 1'b0; mem_ready = 1'b0;

        // Reset state: enables and selects 0, immsrc follows op
        #3;
        rst_vec = '0; rst_vec.immsrc = 2'b01;
        check("reset_sw", 32'(actual), 32'(rst_vec));
        op = JAL; mem_ready = 1'b1; zero = 1'b1;
        #1;
        rst_vec.immsrc = 2'b11;
        check("reset_jal", 32'(actual), 32'(rst_vec));
        @(posedge clk); @(posedge clk); #1;
        check("reset_held", 32'(actual), 32'(rst_vec));

        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;

        // Directed instructions
        issue(LW,   0, 0, -1, 1'b0);
        issue(LW,   2, 3, -1, 1'b0);
        issue(BEQ,  0, 0,  1, 1'b0);
        issue(BEQ,  0, 0,  0, 1'b0);
        issue(JALR, 0, 0, -1, 1'b0);
        issue(LUI,  0, 0, -1, 1'b0);
        issue(SW,   1, 2, -1, 1'b0);
        issue(RT,   0, 0, -1, 1'b0);
        issue(IT,   0, 0, -1, 1'b0);
        issue(JAL,  0, 0, -1, 1'b0);

        // Randomised instruction stream
        for (int n = 0; n < 300; n++) begin
            ro = op_tab[$urandom_range(0, 7)];
            if (ro == LUI) ro = 7'($urandom);
            issue(ro,
                  rnd() ? 0 : int'($urandom_range(1, 3)),
                  rnd() ? 0 : int'($urandom_range(1, 3)),
                  -1, 1'b0);
        end

        // Every queued expectation must have been seen by the monitor
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset while a store is waiting for memory
        issue(SW, 0, 0, -1, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_memwrite_drop", 32'(memwrite), 32'd0);
        rst_vec = '0; rst_vec.immsrc = 2'b01;
        check("rst_async_word", 32'(actual), 32'(rst_vec));
        @(posedge clk); #1;
        check("rst_hold_word", 32'(actual), 32'(rst_vec));
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b1;
        #1;
        check("post_rst_fetch", 32'(actual),
              32'(mk(1,0,1,1,0,0,0, 2'b10,2'b00,2'b10,2'b00, SW)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
